// File: rtl/two_phase_clk_monitor.sv
// ---------------------------------------------------------------------------
// two_phase_clk_monitor
//
// Oversampling checker for a two-phase non-overlapping clock pair phi1/phi2.
// Both phases are registered on clk. The phase sequence is tracked from those
// samples, and the monitor measures phase widths, counts completed
// phi1->phi2->phi1 cycles and flags overlap, ordering and gap violations.
// "locked" is raised after LOCK_CYCLES consecutive clean cycles.
//
// Parameters:
//   WIDTH_W     - width of the saturating phase-width/gap counters
//   CNT_W       - width of the wrapping completed-cycle counter
//   MIN_GAP     - minimum both-low gap (clk cycles) required between phases
//   LOCK_CYCLES - consecutive clean cycles needed for locked
//
// Ports:
//   clk          in   sampling clock, rising edge
//   reset        in   synchronous active-high reset
//   phi1, phi2   in   clock pair under test
//   phi1_width   out  high time of the last completed phi1 pulse (clk cycles)
//   phi2_width   out  high time of the last completed phi2 pulse (clk cycles)
//   cycle_count  out  completed phi1->phi2->phi1 cycles (wraps)
//   overlap_err  out  sticky: phi1 and phi2 sampled high together
//   order_err    out  sticky: a phase repeated without the other in between
//   gap_err      out  sticky: both-low gap shorter than MIN_GAP / direct handoff
//   locked       out  LOCK_CYCLES clean cycles since last error or reset
// ---------------------------------------------------------------------------
module two_phase_clk_monitor #(
    parameter int WIDTH_W     = 8,
    parameter int CNT_W       = 16,
    parameter int MIN_GAP     = 2,
    parameter int LOCK_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               phi1,
    input  logic               phi2,
    output logic [WIDTH_W-1:0] phi1_width,
    output logic [WIDTH_W-1:0] phi2_width,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               overlap_err,
    output logic               order_err,
    output logic               gap_err,
    output logic               locked
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [WIDTH_W-1:0] W_MAX     = '1;
    localparam logic [WIDTH_W-1:0] W_ONE     = WIDTH_W'(1);
    localparam logic [WIDTH_W-1:0] MIN_GAP_W = WIDTH_W'(MIN_GAP);
    localparam logic [LOCK_W-1:0]  LOCK_VAL  = LOCK_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        P1   = 3'd2,
        G12  = 3'd3,
        P2   = 3'd4,
        G21  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               valid_q, valid_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] gap_q, gap_d;
    logic [WIDTH_W-1:0] phi1_width_q, phi1_width_d;
    logic [WIDTH_W-1:0] phi2_width_q, phi2_width_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic               overlap_q, overlap_d;
    logic               order_q, order_d;
    logic               gap_err_q, gap_err_d;
    logic [LOCK_W-1:0]  clean_q, clean_d;
    logic               dirty_q, dirty_d;
    logic               locked_q, locked_d;

    logic [1:0] smp;
    logic       ov_hit, ord_hit, gap_hit, done, sync, any_err;

    assign smp = {s1_q, s2_q};

    function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
        return (v == W_MAX) ? v : v + W_ONE;
    endfunction

    always_comb begin
        s1_d          = phi1;
        s2_d          = phi2;
        valid_d       = 1'b1;
        state_d       = state_q;
        width_d       = width_q;
        gap_d         = gap_q;
        phi1_width_d  = phi1_width_q;
        phi2_width_d  = phi2_width_q;
        cycle_count_d = cycle_count_q;
        ov_hit        = 1'b0;
        ord_hit       = 1'b0;
        gap_hit       = 1'b0;
        done          = 1'b0;
        sync          = 1'b0;

        // The first sample after reset is the cleared register, not a real
        // observation of the inputs, so it must not arm the tracker.
        if (valid_q) begin
            case (state_q)
                IDLE: begin
                    if (smp == 2'b00) state_d = ARM;
                end
                ARM: begin
                    case (smp)
                        2'b10: begin
                            state_d = P1;
                            width_d = W_ONE;
                            sync    = 1'b1;
                        end
                        2'b01:   state_d = IDLE;
                        2'b00:   state_d = ARM;
                        default: begin
                            ov_hit  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                P1, P2: begin
                    // P1 and P2 are mirror images; own = this phase alone.
                    case (smp)
                        2'b00: begin
                            if (state_q == P1) phi1_width_d = width_q;
                            else               phi2_width_d = width_q;
                            gap_d   = W_ONE;
                            state_d = (state_q == P1) ? G12 : G21;
                        end
                        2'b10, 2'b01: begin
                            if ((smp == 2'b10) == (state_q == P1)) begin
                                width_d = sat_inc(width_q);
                            end else begin
                                // direct handoff with no both-low sample
                                gap_hit = 1'b1;
                                width_d = W_ONE;
                                state_d = (state_q == P1) ? P2 : P1;
                            end
                        end
                        default: begin
                            ov_hit  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                G12, G21: begin
                    case (smp)
                        2'b00: gap_d = sat_inc(gap_q);
                        2'b10, 2'b01: begin
                            width_d = W_ONE;
                            state_d = (smp == 2'b10) ? P1 : P2;
                            if ((smp == 2'b01) == (state_q == G12)) begin
                                // expected next phase: gap check
                                if (gap_q < MIN_GAP_W) gap_hit = 1'b1;
                                if (state_q == G21) done = 1'b1;
                            end else begin
                                ord_hit = 1'b1;
                            end
                        end
                        default: begin
                            ov_hit  = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end

        any_err   = ov_hit | ord_hit | gap_hit;
        overlap_d = overlap_q | ov_hit;
        order_d   = order_q | ord_hit;
        gap_err_d = gap_err_q | gap_hit;

        if (done) cycle_count_d = cycle_count_q + CNT_W'(1);

        // Errors dominate a simultaneous completion.
        clean_d = clean_q;
        if (any_err) begin
            clean_d = '0;
        end else if (done && !dirty_q && (clean_q != LOCK_VAL)) begin
            clean_d = clean_q + LOCK_W'(1);
        end

        // dirty marks an error somewhere inside the cycle in progress; a new
        // cycle starts clean at synchronisation and at every completion.
        dirty_d = dirty_q;
        if (done || sync) dirty_d = 1'b0;
        else if (any_err) dirty_d = 1'b1;

        locked_d = (clean_d == LOCK_VAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            valid_q       <= 1'b0;
            width_q       <= '0;
            gap_q         <= '0;
            phi1_width_q  <= '0;
            phi2_width_q  <= '0;
            cycle_count_q <= '0;
            overlap_q     <= 1'b0;
            order_q       <= 1'b0;
            gap_err_q     <= 1'b0;
            clean_q       <= '0;
            dirty_q       <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            valid_q       <= valid_d;
            width_q       <= width_d;
            gap_q         <= gap_d;
            phi1_width_q  <= phi1_width_d;
            phi2_width_q  <= phi2_width_d;
            cycle_count_q <= cycle_count_d;
            overlap_q     <= overlap_d;
            order_q       <= order_d;
            gap_err_q     <= gap_err_d;
            clean_q       <= clean_d;
            dirty_q       <= dirty_d;
            locked_q      <= locked_d;
        end
    end

    assign phi1_width  = phi1_width_q;
    assign phi2_width  = phi2_width_q;
    assign cycle_count = cycle_count_q;
    assign overlap_err = overlap_q;
    assign order_err   = order_q;
    assign gap_err     = gap_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_two_phase_clk_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for two_phase_clk_monitor.
// A run-length reference model works on the stream of registered samples:
// phase widths are the lengths of single-phase runs, gaps are the lengths of
// both-low runs, and errors follow from which phase a run follows.
// A narrow cycle counter is used so that wrap-around is reached quickly.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_two_phase_clk_monitor;

    localparam int WIDTH_W     = 8;
    localparam int CNT_W       = 5;
    localparam int MIN_GAP     = 2;
    localparam int LOCK_CYCLES = 4;
    localparam int W_MAX       = (1 << WIDTH_W) - 1;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               phi1  = 1'b0;
    logic               phi2  = 1'b0;
    logic [WIDTH_W-1:0] phi1_width;
    logic [WIDTH_W-1:0] phi2_width;
    logic [CNT_W-1:0]   cycle_count;
    logic               overlap_err;
    logic               order_err;
    logic               gap_err;
    logic               locked;

    two_phase_clk_monitor #(
        .WIDTH_W    (WIDTH_W),
        .CNT_W      (CNT_W),
        .MIN_GAP    (MIN_GAP),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .phi1       (phi1),
        .phi2       (phi2),
        .phi1_width (phi1_width),
        .phi2_width (phi2_width),
        .cycle_count(cycle_count),
        .overlap_err(overlap_err),
        .order_err  (order_err),
        .gap_err    (gap_err),
        .locked     (locked)
    );

    always #0.5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_valid, m_s, m_prev, m_run, m_stage, m_last;
    int m_p1w, m_p2w, m_cc, m_ov, m_ord, m_gap, m_clean, m_cyc_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_s = 0; m_prev = 0; m_run = 0; m_stage = 0; m_last = 0;
        m_p1w = 0; m_p2w = 0; m_cc = 0; m_ov = 0; m_ord = 0; m_gap = 0;
        m_clean = 0; m_cyc_err = 0;
    endtask

    // cur encodes a sample as phi1*2+phi2: 0 both low, 2 phi1, 1 phi2, 3 both
    task automatic model_sample(input int cur);
        int  prev_run;
        bit  ov, ord, gp, done;
        prev_run = m_run;
        ov = 0; ord = 0; gp = 0; done = 0;
        if (m_stage == 0) begin
            if (cur == 0) m_stage = 1;
        end else if (m_stage == 1) begin
            if (cur == 3) begin
                ov = 1; m_stage = 0;
            end else if (cur == 1) begin
                m_stage = 0;
            end else if (cur == 2) begin
                m_stage = 2; m_last = 1; m_cyc_err = 0;
            end
        end else if (cur == 3) begin
            ov = 1; m_stage = 0;
        end else if (cur != m_prev) begin
            if (cur == 0) begin
                if (m_prev == 2) m_p1w = (prev_run > W_MAX) ? W_MAX : prev_run;
                else             m_p2w = (prev_run > W_MAX) ? W_MAX : prev_run;
            end else begin
                int own;
                own = (cur == 2) ? 1 : 2;
                if (m_prev != 0) gp = 1;             // direct handoff
                else if (m_last == own) ord = 1;     // same phase again
                else begin
                    if (prev_run < MIN_GAP) gp = 1;
                    if (own == 1) done = 1;
                end
                m_last = own;
            end
        end
        m_run  = (cur == m_prev) ? m_run + 1 : 1;
        m_prev = cur;

        if (ov)  m_ov  = 1;
        if (ord) m_ord = 1;
        if (gp)  m_gap = 1;
        if (done) m_cc = (m_cc + 1) % (1 << CNT_W);
        if (ov || ord || gp) m_clean = 0;
        else if (done && !m_cyc_err && m_clean < LOCK_CYCLES) m_clean++;
        if (done) m_cyc_err = 0;
        else if (ov || ord || gp) m_cyc_err = 1;
        if (done)
            $display("cycle done: count=%0d phi1_width=%0d phi2_width=%0d clean=%0d err=%0d",
                     m_cc, m_p1w, m_p2w, m_clean, (ov || ord || gp));
    endtask

    task automatic model_edge(input logic r, input logic a, input logic b);
        if (r) begin
            model_reset();
        end else begin
            if (m_valid != 0) model_sample(m_s);
            m_s     = (a ? 2 : 0) + (b ? 1 : 0);
            m_valid = 1;
        end
    endtask

    task automatic compare_all();
        check("phi1_width",  32'(phi1_width),  m_p1w);
        check("phi2_width",  32'(phi2_width),  m_p2w);
        check("cycle_count", 32'(cycle_count), m_cc);
        check("overlap_err", 32'(overlap_err), m_ov);
        check("order_err",   32'(order_err),   m_ord);
        check("gap_err",     32'(gap_err),     m_gap);
        check("locked",      32'(locked),      (m_clean == LOCK_CYCLES) ? 1 : 0);
    endtask

    // one clk: drive at the falling edge, model the rising edge, compare at
    // the next falling edge
    task automatic step(input logic r, input logic a, input logic b);
        reset = r; phi1 = a; phi2 = b;
        @(posedge clk);
        model_edge(r, a, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, a, b);
    endtask

    task automatic period(input int w1, input int g1, input int w2, input int g2);
        hold(1'b1, 1'b0, w1);
        hold(1'b0, 1'b0, g1);
        hold(1'b0, 1'b1, w2);
        hold(1'b0, 1'b0, g2);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int sel, w1, g1, w2, g2;
        model_reset();
        @(negedge clk);

        // reset state
        do_reset();
        check("rst_phi1_width", 32'(phi1_width), 0);
        check("rst_cycle_count", 32'(cycle_count), 0);
        check("rst_errs", 32'({overlap_err, order_err, gap_err}), 0);
        check("rst_locked", 32'(locked), 0);

        // nominal 50-clk stream, phi1 high from t=0
        for (int t = 0; t < 550; t++) begin
            int ph;
            ph = t % 50;
            step(1'b0, ph < 20, (ph >= 25) && (ph < 45));
            if (t == 260) begin
                check("nom_cc_260", 32'(cycle_count), 4);
                check("nom_locked_260", 32'(locked), 1);
                check("nom_phi1_width", 32'(phi1_width), 20);
                check("nom_phi2_width", 32'(phi2_width), 20);
                check("nom_no_err", 32'({overlap_err, order_err, gap_err}), 0);
            end
            if (t == 505) check("nom_cc_505", 32'(cycle_count), 9);
        end

        // overlap: phi2 rises 2 clk before phi1 falls
        hold(1'b1, 1'b0, 18);
        hold(1'b1, 1'b1, 2);
        check("ovl_flag", 32'(overlap_err), 1);
        check("ovl_unlock", 32'(locked), 0);
        hold(1'b0, 1'b1, 20);
        hold(1'b0, 1'b0, 5);
        for (int i = 0; i < 7; i++) period(20, 5, 20, 5);
        check("ovl_relock", 32'(locked), 1);
        check("ovl_sticky", 32'(overlap_err), 1);

        // short gap
        do_reset();
        hold(1'b0, 1'b0, 5);
        period(20, 5, 20, 5);
        check("gap_before", 32'(gap_err), 0);
        period(20, 1, 20, 5);
        period(20, 5, 20, 5);
        check("gap_short", 32'(gap_err), 1);
        check("gap_phi1_width", 32'(phi1_width), 20);
        check("gap_phi2_width", 32'(phi2_width), 20);

        // direct handoff
        do_reset();
        hold(1'b0, 1'b0, 5);
        period(20, 0, 20, 5);
        hold(1'b1, 1'b0, 2);
        check("gap_handoff", 32'(gap_err), 1);

        // order: two phi1 pulses with no phi2 between them
        do_reset();
        hold(1'b0, 1'b0, 5);
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 5);
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 5);
        check("ord_flag", 32'(order_err), 1);
        check("ord_no_ovl", 32'(overlap_err), 0);
        check("ord_no_gap", 32'(gap_err), 0);

        // width saturation
        do_reset();
        hold(1'b0, 1'b0, 5);
        hold(1'b1, 1'b0, 300);
        hold(1'b0, 1'b0, 5);
        check("sat_phi1_width", 32'(phi1_width), W_MAX);
        for (int i = 0; i < 3; i++) period(20, 5, 20, 5);

        // cycle counter wrap (34 completions modulo 32)
        do_reset();
        hold(1'b0, 1'b0, 5);
        for (int i = 0; i < 34; i++) period(20, 5, 20, 5);
        hold(1'b1, 1'b0, 2);
        check("wrap_cc", 32'(cycle_count), 34 % (1 << CNT_W));

        // mid-run reset while phi2 is high
        hold(1'b1, 1'b0, 18);
        hold(1'b0, 1'b0, 5);
        hold(1'b0, 1'b1, 10);
        step(1'b1, 1'b0, 1'b1);
        check("mrst_cc", 32'(cycle_count), 0);
        check("mrst_width", 32'({phi1_width, phi2_width}), 0);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 5);
        for (int i = 0; i < 6; i++) period(20, 5, 20, 5);
        check("mrst_locked", 32'(locked), 1);
        check("mrst_no_err", 32'({overlap_err, order_err, gap_err}), 0);

        // randomized mix of clean and faulty pulse trains
        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 19);
            w1  = $urandom_range(1, 30);
            g1  = $urandom_range(0, 6);
            w2  = $urandom_range(1, 30);
            g2  = $urandom_range(0, 6);
            if (sel == 0) begin
                do_reset();
                hold(1'b0, 1'b0, g1);
            end else if (sel == 1) begin
                hold(1'b1, 1'b0, w1);
                hold(1'b1, 1'b1, $urandom_range(1, 3));
                hold(1'b0, 1'b1, w2);
                hold(1'b0, 1'b0, g2);
            end else if (sel == 2) begin
                hold(1'b1, 1'b0, w1);
                hold(1'b0, 1'b0, g1 + 1);
                hold(1'b1, 1'b0, w2);
                hold(1'b0, 1'b0, g2 + 1);
            end else if (sel == 3) begin
                hold(1'b1, 1'b0, $urandom_range(250, 300));
                hold(1'b0, 1'b0, g1 + 1);
            end else begin
                period(w1, g1, w2, g2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
